// File: rtl/vga3_pkg.sv
// Purpose: shared scanout-scheduler state encodings and strobe helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } scanState_t;

    // An edge-clocked vmmu strobe may only rise from a low level, so a request
    // is honoured only while the strobe is currently low.
    function automatic logic strobeAllowed(input logic strobeNow, input logic want);
        return want && !strobeNow;
    endfunction

endpackage

// File: rtl/strobe_gen.sv
// Purpose: registered pulse for an edge-clocked vmmu queue strobe.
// Latency: Strobe is high the cycle after Fire, for exactly one cycle.
// Backpressure: Want is refused (Fire=0) while Strobe is high, forcing >=1 low cycle.
// Ports: MemClk/Reset (sync, active-high), Want request in, Fire accept out, Strobe to vmmu.
module strobe_gen
    import vga3_pkg::*;
(
    input  logic MemClk,
    input  logic Reset,
    input  logic Want,
    output logic Fire,
    output logic Strobe
);

    assign Fire = strobeAllowed(Strobe, Want);

    always_ff @(posedge MemClk) begin
        if (Reset) begin
            Strobe <= 1'b0;
        end else begin
            Strobe <= Fire;
        end
    end

endmodule

// File: rtl/vmmu_scan_sched.sv
// Purpose: per-line scanout byte fetcher between vmmu read queues and the pixel stream.
// Latency: LineReq -> first PushReadReq high 1 cycle; pop -> PixelValid 1 cycle.
// Backpressure: credits stop pushes; a held pixel (Valid && !Ready) stops pops.
// Ports: LineReq/LineAddr start a line, LineBusy/LineOverrun status; PixelData/Valid/Ready
//        output stream; ReadAddrOut/PushReadReq/ReadReqQueueFull request side of vmmu;
//        ReadDataIn/ReadDataClkOut/ReadDataQueueEmpty data side of vmmu.
module vmmu_scan_sched
    import vga3_pkg::*;
#(
    parameter int AWIDTH     = 18,
    parameter int DWIDTH     = 8,
    parameter int LINE_BYTES = 640,
    parameter int CREDITS    = 8,
    parameter int CWIDTH     = 4
) (
    input  logic              MemClk,
    input  logic              Reset,
    input  logic              LineReq,
    input  logic [AWIDTH-1:0] LineAddr,
    output logic              LineBusy,
    output logic              LineOverrun,
    output logic [DWIDTH-1:0] PixelData,
    output logic              PixelValid,
    input  logic              PixelReady,
    output logic [AWIDTH-1:0] ReadAddrOut,
    output logic              PushReadReq,
    input  logic              ReadReqQueueFull,
    input  logic [DWIDTH-1:0] ReadDataIn,
    output logic              ReadDataClkOut,
    input  logic              ReadDataQueueEmpty
);

    localparam logic [15:0]       LINE_LEN = 16'(LINE_BYTES);
    localparam logic [CWIDTH-1:0] CRED_MAX = CWIDTH'(CREDITS);

    scanState_t        state, nextState;
    logic [AWIDTH-1:0] base;
    logic [AWIDTH-1:0] pushAddr;
    logic [15:0]       issued, popped, delivered;
    logic [CWIDTH-1:0] credit;
    logic              lineStart, pixelTake, outFree, captureNow;
    logic              pushWant, pushFire, popWant, popFire;

    assign lineStart = LineReq && (state == ST_IDLE);
    assign pixelTake = PixelValid && PixelReady;
    assign outFree   = !PixelValid || pixelTake;
    // The pop strobe is high exactly during the cycle the popped byte sits on ReadDataIn.
    assign captureNow = ReadDataClkOut;
    assign LineBusy   = (state != ST_IDLE);

    // The first request of a line is issued straight from LineAddr so it leaves
    // one cycle after LineReq; credit is always zero in IDLE.
    assign pushAddr = lineStart ? LineAddr : base + AWIDTH'(issued);
    assign pushWant = !ReadReqQueueFull &&
                      (lineStart ||
                       ((state == ST_FETCH) && (issued < LINE_LEN) && (credit < CRED_MAX)));
    // popFire implies no capture is pending, so freeing the output register now
    // guarantees room when the byte lands next cycle.
    assign popWant  = (state != ST_IDLE) && !ReadDataQueueEmpty && (popped < LINE_LEN) && outFree;

    strobe_gen pushStrobe (
        .MemClk (MemClk),
        .Reset  (Reset),
        .Want   (pushWant),
        .Fire   (pushFire),
        .Strobe (PushReadReq)
    );

    strobe_gen popStrobe (
        .MemClk (MemClk),
        .Reset  (Reset),
        .Want   (popWant),
        .Fire   (popFire),
        .Strobe (ReadDataClkOut)
    );

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  if (LineReq) nextState = ST_FETCH;
            ST_FETCH: if (issued == LINE_LEN) nextState = ST_DRAIN;
            ST_DRAIN: if (delivered == LINE_LEN) nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge MemClk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            base        <= '0;
            issued      <= '0;
            popped      <= '0;
            delivered   <= '0;
            credit      <= '0;
            LineOverrun <= 1'b0;
            PixelData   <= '0;
            PixelValid  <= 1'b0;
            ReadAddrOut <= '0;
        end else begin
            state <= nextState;

            // Includes the DRAIN->IDLE cycle, where state is still DRAIN.
            if (LineReq && (state != ST_IDLE)) LineOverrun <= 1'b1;

            if (lineStart) begin
                base      <= LineAddr;
                popped    <= '0;
                delivered <= '0;
                issued    <= {15'd0, pushFire};
            end else if (pushFire) begin
                issued <= issued + 16'd1;
            end

            if (pushFire) ReadAddrOut <= pushAddr;
            if (popFire)  popped <= popped + 16'd1;

            case ({pushFire, captureNow})
                2'b10:   credit <= credit + CWIDTH'(1);
                2'b01:   credit <= credit - CWIDTH'(1);
                default: credit <= credit;
            endcase

            if (captureNow) begin
                PixelData  <= ReadDataIn;
                PixelValid <= 1'b1;
            end else if (pixelTake) begin
                PixelValid <= 1'b0;
            end

            if (pixelTake) delivered <= delivered + 16'd1;
        end
    end

endmodule

// File: tb/tb_vmmu_scan_sched.sv
// Purpose: directed scoreboard bench for vmmu_scan_sched against a behavioural vmmu + SRAM.
// Latency: model services one read request per cycle (one per 4 under write load).
// Backpressure: model reports full at 4 requests; PixelReady driven by the bench.
module tb_vmmu_scan_sched;

    localparam int AW      = 18;
    localparam int LINE    = 16;
    localparam int CRED    = 8;
    localparam int REQSIZE = 4;

    logic          MemClk = 1'b0;
    logic          Reset = 1'b1;
    logic          LineReq = 1'b0;
    logic [AW-1:0] LineAddr = '0;
    logic          LineBusy, LineOverrun, PixelValid, PushReadReq, ReadDataClkOut;
    logic [7:0]    PixelData;
    logic          PixelReady = 1'b0;
    logic [AW-1:0] ReadAddrOut;
    logic          ReadReqQueueFull = 1'b0;
    logic [7:0]    ReadDataIn = '0;
    logic          ReadDataQueueEmpty = 1'b1;

    always #5 MemClk = ~MemClk;

    vmmu_scan_sched #(
        .AWIDTH(AW), .DWIDTH(8), .LINE_BYTES(LINE), .CREDITS(CRED), .CWIDTH(4)
    ) dut (
        .MemClk             (MemClk),
        .Reset              (Reset),
        .LineReq            (LineReq),
        .LineAddr           (LineAddr),
        .LineBusy           (LineBusy),
        .LineOverrun        (LineOverrun),
        .PixelData          (PixelData),
        .PixelValid         (PixelValid),
        .PixelReady         (PixelReady),
        .ReadAddrOut        (ReadAddrOut),
        .PushReadReq        (PushReadReq),
        .ReadReqQueueFull   (ReadReqQueueFull),
        .ReadDataIn         (ReadDataIn),
        .ReadDataClkOut     (ReadDataClkOut),
        .ReadDataQueueEmpty (ReadDataQueueEmpty)
    );

    // ---------------- behavioural SRAM + vmmu read path ----------------
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] reqQ[$];
    logic [7:0]    datQ[$];
    logic [AW-1:0] gotAddrQ[$];
    logic [7:0]    gotQ[$];
    logic          prevPush = 1'b0, prevPop = 1'b0;
    bit            writeLoad = 1'b0;
    int            svcTick = 0;
    int            strobeViol = 0, outstandingOvf = 0, dataUnderflow = 0;

    // Everything the model does happens on the falling edge, away from DUT sampling.
    always @(negedge MemClk) begin
        if (Reset) begin
            reqQ.delete();
            datQ.delete();
            ReadDataIn = '0;
            prevPush   = 1'b0;
            prevPop    = 1'b0;
        end else begin
            if ((PushReadReq && prevPush) || (ReadDataClkOut && prevPop)) strobeViol++;
            prevPush = PushReadReq;
            prevPop  = ReadDataClkOut;
            if (PushReadReq) begin
                if (reqQ.size() >= REQSIZE) outstandingOvf++;
                reqQ.push_back(ReadAddrOut);
                gotAddrQ.push_back(ReadAddrOut);
            end
            if (ReadDataClkOut) begin
                if (datQ.size() == 0) dataUnderflow++;
                else ReadDataIn = datQ.pop_front();
            end
            if (PixelValid && PixelReady) gotQ.push_back(PixelData);
            svcTick++;
            // Saturating write traffic wins arbitration three cycles out of four.
            if (reqQ.size() > 0 && (!writeLoad || (svcTick % 4) == 0))
                datQ.push_back(mem[reqQ.pop_front()]);
            if (reqQ.size() + datQ.size() > CRED) outstandingOvf++;
        end
        ReadReqQueueFull   = (reqQ.size() >= REQSIZE);
        ReadDataQueueEmpty = (datQ.size() == 0);
    end

    // ---------------- scoreboard ----------------
    logic [7:0]    expQ[$];
    logic [AW-1:0] expAddrQ[$];
    int            nAssert = 0, nFail = 0;
    int            lineGot = 0, lineAddrCnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] req);
        nAssert++;
        assert (got === req) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge MemClk);
        #1;
    endtask

    task automatic drain();
        logic [7:0]    g;
        logic [AW-1:0] a;
        while (gotQ.size() > 0) begin
            g = gotQ.pop_front();
            lineGot++;
            if (expQ.size() == 0) begin
                nAssert++;
                nFail++;
                $error("FAIL pixel_extra observed=%0h expected=none", g);
            end else check("pixel_data", 32'(g), 32'(expQ.pop_front()));
        end
        while (gotAddrQ.size() > 0) begin
            a = gotAddrQ.pop_front();
            lineAddrCnt++;
            if (expAddrQ.size() == 0) begin
                nAssert++;
                nFail++;
                $error("FAIL read_addr_extra observed=%0h expected=none", a);
            end else check("read_addr", 32'(a), 32'(expAddrQ.pop_front()));
        end
    endtask

    task automatic startLine(input logic [AW-1:0] addr);
        logic [AW-1:0] a;
        lineGot     = 0;
        lineAddrCnt = 0;
        for (int i = 0; i < LINE; i++) begin
            a = addr + AW'(i);
            expAddrQ.push_back(a);
            expQ.push_back(mem[a]);
        end
        LineAddr = addr;
        LineReq  = 1'b1;
        tick(1);
        LineReq  = 1'b0;
    endtask

    task automatic runLine(input int budget, input bit randReady);
        int n = 0;
        while (n < budget && (LineBusy || expQ.size() > 0)) begin
            if (randReady) PixelReady = 1'($urandom_range(0, 1));
            tick(1);
            drain();
            n++;
        end
        check("line_idle", 32'(LineBusy), 32'd0);
        check("line_bytes", 32'(lineGot), 32'(LINE));
        check("line_reads", 32'(lineAddrCnt), 32'(LINE));
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_busy"},    32'(LineBusy), 32'd0);
        check({tag, "_overrun"}, 32'(LineOverrun), 32'd0);
        check({tag, "_valid"},   32'(PixelValid), 32'd0);
        check({tag, "_data"},    32'(PixelData), 32'd0);
        check({tag, "_push"},    32'(PushReadReq), 32'd0);
        check({tag, "_pop"},     32'(ReadDataClkOut), 32'd0);
        check({tag, "_addr"},    32'(ReadAddrOut), 32'd0);
    endtask

    initial begin
        logic [7:0] held;
        int         n;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'((i * 37) ^ (i >> 7) ^ 8'h5A);

        // Reset state
        tick(3);
        checkResetOutputs("reset");
        Reset = 1'b0;
        tick(2);

        // 1: plain line, consumer always ready; first push one cycle after LineReq
        PixelReady = 1'b1;
        startLine(18'h00100);
        check("first_push_latency", 32'(PushReadReq), 32'd1);
        check("busy_after_req", 32'(LineBusy), 32'd1);
        runLine(400, 1'b0);

        // 2: consumer stalled - credits cap issue at CREDITS plus the one byte
        //    already captured into the output register
        PixelReady = 1'b0;
        startLine(18'h02000);
        tick(200);
        drain();
        check("stall_pushes", 32'(lineAddrCnt), 32'(CRED + 1));
        check("stall_valid", 32'(PixelValid), 32'd1);
        held = PixelData;
        tick(20);
        drain();
        check("stall_data_hold", 32'(PixelData), 32'(held));
        check("stall_pushes_hold", 32'(lineAddrCnt), 32'(CRED + 1));
        check("stall_no_delivery", 32'(lineGot), 32'd0);
        PixelReady = 1'b1;
        runLine(400, 1'b0);

        // 3: address wrap at the top of memory
        startLine(18'h3FFFC);
        runLine(400, 1'b0);

        // 4: LineReq while busy is ignored and sets sticky overrun
        check("overrun_clear", 32'(LineOverrun), 32'd0);
        startLine(18'h00500);
        tick(4);
        LineAddr = 18'h09000;
        LineReq  = 1'b1;
        tick(1);
        LineReq  = 1'b0;
        check("overrun_set", 32'(LineOverrun), 32'd1);
        runLine(400, 1'b0);
        startLine(18'h00600);
        runLine(400, 1'b0);
        check("overrun_sticky", 32'(LineOverrun), 32'd1);

        // 5: reset after five bytes of a line
        startLine(18'h00700);
        n = 0;
        while (n < 200 && lineGot < 5) begin
            tick(1);
            drain();
            n++;
        end
        check("reset_mid_reached", 32'(lineGot >= 5), 32'd1);
        Reset = 1'b1;
        tick(1);
        checkResetOutputs("midreset");
        Reset = 1'b0;
        expQ.delete();
        expAddrQ.delete();
        gotQ.delete();
        gotAddrQ.delete();
        tick(2);
        startLine(18'h00800);
        runLine(400, 1'b0);

        // 6: saturating write traffic with a jittery consumer
        writeLoad = 1'b1;
        startLine(18'h01234);
        runLine(2000, 1'b1);
        writeLoad  = 1'b0;
        PixelReady = 1'b1;

        check("strobe_back_to_back", 32'(strobeViol), 32'd0);
        check("vmmu_outstanding_ovf", 32'(outstandingOvf), 32'd0);
        check("vmmu_data_underflow", 32'(dataUnderflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
